// File: rtl/surf_wb_intercon_if.sv
// Wishbone point-to-point link between a master and the interconnect or the interconnect and a slave.
// AW sets the address width carried on the link.
interface surf_wb_intercon_if #(parameter int AW = 22);
   logic          cyc;
   logic          stb;
   logic          we;
   logic [AW-1:0] adr;
   logic [31:0]   wdat;
   logic [3:0]    sel;
   logic          ack;
   logic          err;
   logic [31:0]   rdat;

   modport master (output cyc, stb, we, adr, wdat, sel, input  ack, err, rdat);
   modport slave  (input  cyc, stb, we, adr, wdat, sel, output ack, err, rdat);
endinterface

// File: rtl/surf_wb_intercon.sv
// Two-master round-robin Wishbone interconnect onto id/notch/agc/beam/rfdc, with unmapped and timeout errors.
// Optional SURF_WB_ERR_CAPTURE_EN adds err_adr_o/err_src_o/err_cnt_o error capture outputs.
module surf_wb_intercon #(
   parameter int TIMEOUT_CYCLES = 1023,
   parameter int TIMEOUT_BITS   = 10
) (
   input  logic                  wb_clk_i,
   input  logic                  wb_rst_n_i,
   surf_wb_intercon_if.slave     m0,
   surf_wb_intercon_if.slave     m1,
   surf_wb_intercon_if.master    id,
   surf_wb_intercon_if.master    notch,
   surf_wb_intercon_if.master    agc,
   surf_wb_intercon_if.master    beam,
   surf_wb_intercon_if.master    rfdc
`ifdef SURF_WB_ERR_CAPTURE_EN
   ,
   output logic [21:0]           err_adr_o,
   output logic [1:0]            err_src_o,
   output logic [15:0]           err_cnt_o
`endif
);

   typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

   state_t                  state, state_nxt;
   logic                    last_gnt, last_gnt_nxt;
   logic                    g0, g1;
   logic                    g_cyc, g_stb, g_we;
   logic [21:0]             g_adr;
   logic [31:0]             g_wdat;
   logic [3:0]              g_sel;
   logic                    hit_rfdc, hit_lo, unmapped;
   logic [4:0]              tgt;
   logic [TIMEOUT_BITS-1:0] to_cnt;
   logic                    gated_q, to_fire, gate, live;
   logic                    un_err_q;
   logic [4:0]              s_cyc, s_stb, s_ack_v, s_err_v;
   logic                    s_ack, s_err, m_ack, m_err;
   logic [31:0]             s_dat;

   // ---------------- arbiter ----------------
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         state    <= IDLE;
         last_gnt <= 1'b1;
      end else begin
         state    <= state_nxt;
         last_gnt <= last_gnt_nxt;
      end
   end

   always_comb begin
      state_nxt    = state;
      last_gnt_nxt = last_gnt;
      case (state)
         IDLE: begin
            if (m0.cyc && m1.cyc) state_nxt = last_gnt ? GNT0 : GNT1;
            else if (m0.cyc)      state_nxt = GNT0;
            else if (m1.cyc)      state_nxt = GNT1;
         end
         GNT0: if (!m0.cyc) begin
            state_nxt    = IDLE;
            last_gnt_nxt = 1'b0;
         end
         GNT1: if (!m1.cyc) begin
            state_nxt    = IDLE;
            last_gnt_nxt = 1'b1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign g0     = (state == GNT0);
   assign g1     = (state == GNT1);
   assign g_cyc  = (g0 && m0.cyc) || (g1 && m1.cyc);
   assign g_stb  = (g0 && m0.cyc && m0.stb) || (g1 && m1.cyc && m1.stb);
   assign g_we   = g0 ? m0.we   : (g1 ? m1.we   : 1'b0);
   assign g_adr  = g0 ? m0.adr  : (g1 ? m1.adr  : '0);
   assign g_wdat = g0 ? m0.wdat : (g1 ? m1.wdat : '0);
   assign g_sel  = g0 ? m0.sel  : (g1 ? m1.sel  : '0);

   // ---------------- decode ----------------
   assign hit_rfdc = g_adr[21];
   assign hit_lo   = !g_adr[21] && (g_adr[20:14] == '0);
   assign unmapped = !hit_rfdc && !hit_lo;

   always_comb begin
      tgt = '0;
      if (hit_rfdc)    tgt[4] = 1'b1;
      else if (hit_lo) tgt[g_adr[13:12]] = 1'b1;
   end

   // ---------------- timeout / error generation ----------------
   // The firing cycle already gates the slave, so a late ack can never race the forced err.
   assign to_fire = g_stb && !unmapped && !gated_q && (to_cnt == TIMEOUT_BITS'(TIMEOUT_CYCLES));
   assign gate    = gated_q || to_fire;
   assign live    = g_cyc && !gate;

   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         to_cnt   <= '0;
         gated_q  <= 1'b0;
         un_err_q <= 1'b0;
      end else begin
         if (g_stb && !unmapped && !gate && !s_ack && !s_err) to_cnt <= to_cnt + 1'b1;
         else                                                to_cnt <= '0;
         if (!g_cyc)       gated_q <= 1'b0;
         else if (to_fire) gated_q <= 1'b1;
         un_err_q <= g_stb && unmapped && !un_err_q;
      end
   end

   // ---------------- slave routing ----------------
   assign s_cyc   = live ? tgt : '0;
   assign s_stb   = g_stb ? s_cyc : '0;
   assign s_ack_v = {rfdc.ack, beam.ack, agc.ack, notch.ack, id.ack};
   assign s_err_v = {rfdc.err, beam.err, agc.err, notch.err, id.err};
   assign s_ack   = |(s_cyc & s_ack_v);
   assign s_err   = |(s_cyc & s_err_v);

   always_comb begin
      s_dat = '0;
      if      (s_cyc[0]) s_dat = id.rdat;
      else if (s_cyc[1]) s_dat = notch.rdat;
      else if (s_cyc[2]) s_dat = agc.rdat;
      else if (s_cyc[3]) s_dat = beam.rdat;
      else if (s_cyc[4]) s_dat = rfdc.rdat;
   end

   assign id.cyc     = s_cyc[0];
   assign id.stb     = s_stb[0];
   assign id.we      = s_cyc[0] && g_we;
   assign id.adr     = s_cyc[0] ? g_adr[11:0] : '0;
   assign id.wdat    = s_cyc[0] ? g_wdat : '0;
   assign id.sel     = s_cyc[0] ? g_sel : '0;

   assign notch.cyc  = s_cyc[1];
   assign notch.stb  = s_stb[1];
   assign notch.we   = s_cyc[1] && g_we;
   assign notch.adr  = s_cyc[1] ? g_adr[11:0] : '0;
   assign notch.wdat = s_cyc[1] ? g_wdat : '0;
   assign notch.sel  = s_cyc[1] ? g_sel : '0;

   assign agc.cyc    = s_cyc[2];
   assign agc.stb    = s_stb[2];
   assign agc.we     = s_cyc[2] && g_we;
   assign agc.adr    = s_cyc[2] ? g_adr[11:0] : '0;
   assign agc.wdat   = s_cyc[2] ? g_wdat : '0;
   assign agc.sel    = s_cyc[2] ? g_sel : '0;

   assign beam.cyc   = s_cyc[3];
   assign beam.stb   = s_stb[3];
   assign beam.we    = s_cyc[3] && g_we;
   assign beam.adr   = s_cyc[3] ? g_adr[11:0] : '0;
   assign beam.wdat  = s_cyc[3] ? g_wdat : '0;
   assign beam.sel   = s_cyc[3] ? g_sel : '0;

   assign rfdc.cyc   = s_cyc[4];
   assign rfdc.stb   = s_stb[4];
   assign rfdc.we    = s_cyc[4] && g_we;
   assign rfdc.adr   = s_cyc[4] ? g_adr[16:0] : '0;
   assign rfdc.wdat  = s_cyc[4] ? g_wdat : '0;
   assign rfdc.sel   = s_cyc[4] ? g_sel : '0;

   // ---------------- master responses ----------------
   assign m_err   = g_cyc && (s_err || un_err_q || to_fire);
   assign m_ack   = s_ack && !m_err;

   assign m0.ack  = g0 && m_ack;
   assign m0.err  = g0 && m_err;
   assign m0.rdat = (g0 && m_ack) ? s_dat : '0;
   assign m1.ack  = g1 && m_ack;
   assign m1.err  = g1 && m_err;
   assign m1.rdat = (g1 && m_ack) ? s_dat : '0;

`ifdef SURF_WB_ERR_CAPTURE_EN
   always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
      if (!wb_rst_n_i) begin
         err_adr_o <= '0;
         err_src_o <= '0;
         err_cnt_o <= '0;
      end else if (m_err) begin
         err_adr_o <= g_adr;
         err_src_o <= to_fire ? 2'd2 : (un_err_q ? 2'd1 : 2'd0);
         if (err_cnt_o != 16'hFFFF) err_cnt_o <= err_cnt_o + 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_surf_wb_intercon.sv
// Randomized bench for surf_wb_intercon against a transaction-level reference model.
// Build with SURF_WB_ERR_CAPTURE_EN to also check the error capture outputs.
module tb_surf_wb_intercon;
  localparam int TO = 15;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #8 clk = ~clk;

  surf_wb_intercon_if #(.AW(22)) m0_if ();
  surf_wb_intercon_if #(.AW(22)) m1_if ();
  surf_wb_intercon_if #(.AW(12)) id_if ();
  surf_wb_intercon_if #(.AW(12)) notch_if ();
  surf_wb_intercon_if #(.AW(12)) agc_if ();
  surf_wb_intercon_if #(.AW(12)) beam_if ();
  surf_wb_intercon_if #(.AW(17)) rfdc_if ();

`ifdef SURF_WB_ERR_CAPTURE_EN
  logic [21:0] err_adr;
  logic [1:0]  err_src;
  logic [15:0] err_cnt;
  int          err_cnt_mdl;
`endif

  surf_wb_intercon #(.TIMEOUT_CYCLES(TO), .TIMEOUT_BITS(4)) dut (
    .wb_clk_i(clk), .wb_rst_n_i(rst_n),
    .m0(m0_if), .m1(m1_if),
    .id(id_if), .notch(notch_if), .agc(agc_if), .beam(beam_if), .rfdc(rfdc_if)
`ifdef SURF_WB_ERR_CAPTURE_EN
    , .err_adr_o(err_adr), .err_src_o(err_src), .err_cnt_o(err_cnt)
`endif
  );

  int vecs = 0;
  int miss = 0;

  task automatic chk(string tag, logic [63:0] act, logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic drive_m(int m, logic c, logic s, logic w, logic [21:0] a, logic [31:0] d, logic [3:0] sl);
    if (m == 0) begin
      m0_if.cyc = c; m0_if.stb = s; m0_if.we = w; m0_if.adr = a; m0_if.wdat = d; m0_if.sel = sl;
    end else begin
      m1_if.cyc = c; m1_if.stb = s; m1_if.we = w; m1_if.adr = a; m1_if.wdat = d; m1_if.sel = sl;
    end
  endtask

  task automatic set_resp(int t, logic a, logic e, logic [31:0] d);
    case (t)
      0: begin id_if.ack = a;    id_if.err = e;    id_if.rdat = d;    end
      1: begin notch_if.ack = a; notch_if.err = e; notch_if.rdat = d; end
      2: begin agc_if.ack = a;   agc_if.err = e;   agc_if.rdat = d;   end
      3: begin beam_if.ack = a;  beam_if.err = e;  beam_if.rdat = d;  end
      4: begin rfdc_if.ack = a;  rfdc_if.err = e;  rfdc_if.rdat = d;  end
      default: ;
    endcase
  endtask

  task automatic clr_resp();
    for (int i = 0; i < 5; i++) set_resp(i, 1'b0, 1'b0, 32'h0);
  endtask

  function automatic logic [4:0] stbs();
    return {rfdc_if.stb, beam_if.stb, agc_if.stb, notch_if.stb, id_if.stb};
  endfunction

  function automatic logic [4:0] cycs();
    return {rfdc_if.cyc, beam_if.cyc, agc_if.cyc, notch_if.cyc, id_if.cyc};
  endfunction

  task automatic get_slave(int t, output logic [21:0] a, output logic w, output logic [31:0] d, output logic [3:0] sl);
    a = '0; w = 1'b0; d = '0; sl = '0;
    case (t)
      0: begin a = 22'(id_if.adr);    w = id_if.we;    d = id_if.wdat;    sl = id_if.sel;    end
      1: begin a = 22'(notch_if.adr); w = notch_if.we; d = notch_if.wdat; sl = notch_if.sel; end
      2: begin a = 22'(agc_if.adr);   w = agc_if.we;   d = agc_if.wdat;   sl = agc_if.sel;   end
      3: begin a = 22'(beam_if.adr);  w = beam_if.we;  d = beam_if.wdat;  sl = beam_if.sel;  end
      4: begin a = 22'(rfdc_if.adr);  w = rfdc_if.we;  d = rfdc_if.wdat;  sl = rfdc_if.sel;  end
      default: ;
    endcase
  endtask

  function automatic logic mack(int m); return (m == 0) ? m0_if.ack : m1_if.ack; endfunction
  function automatic logic merr(int m); return (m == 0) ? m0_if.err : m1_if.err; endfunction
  function automatic logic [31:0] mdat(int m); return (m == 0) ? m0_if.rdat : m1_if.rdat; endfunction

  function automatic logic all_out();
    return |{m0_if.ack, m0_if.err, m0_if.rdat, m1_if.ack, m1_if.err, m1_if.rdat,
             id_if.cyc, id_if.stb, id_if.we, id_if.adr, id_if.wdat, id_if.sel,
             notch_if.cyc, notch_if.stb, notch_if.we, notch_if.adr, notch_if.wdat, notch_if.sel,
             agc_if.cyc, agc_if.stb, agc_if.we, agc_if.adr, agc_if.wdat, agc_if.sel,
             beam_if.cyc, beam_if.stb, beam_if.we, beam_if.adr, beam_if.wdat, beam_if.sel,
             rfdc_if.cyc, rfdc_if.stb, rfdc_if.we, rfdc_if.adr, rfdc_if.wdat, rfdc_if.sel};
  endfunction

  // Reference address map: rfdc above 2 MiB, four 4 KiB slaves below 16 KiB, the rest unmapped (5).
  function automatic int ref_target(logic [21:0] a);
    if (int'(a) >= (1 << 21)) return 4;
    if (int'(a) < (1 << 14))  return int'(a) / 4096;
    return 5;
  endfunction

  function automatic logic [21:0] ref_sadr(logic [21:0] a);
    return (ref_target(a) == 4) ? 22'(int'(a) % (1 << 17)) : 22'(int'(a) % 4096);
  endfunction

  // kind: 0 slave acks, 1 slave errs, 2 slave silent. Called just after a rising edge.
  task automatic run_txn(int m, logic [21:0] a, logic w, logic [31:0] d, logic [3:0] sl,
                         int lat, int kind, logic [31:0] rdat);
    int t, exp_cyc, exp_kind, got_cyc, got_kind, first_stb, stb_cnt, stray, other, datz;
    logic [31:0] got_dat;
    logic [4:0]  sv, tmask;
    logic [21:0] sa; logic sw; logic [31:0] sd; logic [3:0] ss;
    t = ref_target(a);
    tmask = (t < 5) ? 5'(1 << t) : 5'b0;
    if (t == 5)         begin exp_cyc = 2;       exp_kind = 2; end
    else if (kind == 2) begin exp_cyc = 1 + TO;  exp_kind = 2; end
    else                begin exp_cyc = 1 + lat; exp_kind = (kind == 0) ? 1 : 2; end
    got_cyc = -1; got_kind = 0; got_dat = '0; first_stb = -1; stb_cnt = 0;
    stray = 0; other = 0; datz = 0;
    drive_m(m, 1'b1, 1'b1, w, a, d, sl);
    for (int c = 1; c <= 40 && got_cyc < 0; c++) begin
      @(posedge clk); #1;
      clr_resp(); #1;
      sv = stbs();
      if (t < 5 && sv[t]) begin
        if (first_stb < 0) begin
          first_stb = c;
          get_slave(t, sa, sw, sd, ss);
          chk("slave_adr", 64'(sa), 64'(ref_sadr(a)));
          chk("slave_wr", 64'({sw, ss, sd}), 64'({w, sl, d}));
        end
        if (stb_cnt == lat && kind < 2) set_resp(t, kind == 0, kind == 1, rdat);
        stb_cnt++;
      end
      if ((sv & ~tmask) != 0) stray++;
      #1;
      if (mack(1 - m) || merr(1 - m) || mdat(1 - m) != 0) other++;
      if (!mack(m) && mdat(m) != 0) datz++;
      if (mack(m) || merr(m)) begin
        got_cyc = c; got_kind = merr(m) ? 2 : 1; got_dat = mdat(m);
      end
    end
    chk("resp_cycle", 64'(got_cyc), 64'(exp_cyc));
    chk("resp_kind", 64'(got_kind), 64'(exp_kind));
    if (exp_kind == 1) chk("read_data", 64'(got_dat), 64'(rdat));
    chk("first_stb", 64'(first_stb), (t == 5) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'd1);
    if (t < 5 && kind == 2) chk("to_stb_cycles", 64'(stb_cnt), 64'(TO));
    chk("stray_or_idle_resp", 64'({stray[15:0], other[15:0], datz[15:0]}), 64'd0);
    // after a timeout the master keeps cyc; the slave stays gated and late acks are dropped
    if (t < 5 && kind == 2) begin
      for (int k = 0; k < 3; k++) begin
        @(posedge clk); #1;
        set_resp(t, 1'b1, 1'b0, rdat); #1;
        chk("gated_late_ack", 64'({stbs(), mack(m), merr(m)}), 64'd0);
      end
    end
`ifdef SURF_WB_ERR_CAPTURE_EN
    if (exp_kind == 2) err_cnt_mdl++;
`endif
    drive_m(m, 1'b0, 1'b0, 1'b0, 22'h0, 32'h0, 4'h0);
    clr_resp();
    step();
    chk("released", 64'({cycs(), stbs()}), 64'd0);
`ifdef SURF_WB_ERR_CAPTURE_EN
    if (exp_kind == 2) begin
      chk("err_adr", 64'(err_adr), 64'(a));
      chk("err_src", 64'(err_src), (t == 5) ? 64'd1 : ((kind == 2) ? 64'd2 : 64'd0));
    end
    chk("err_cnt", 64'(err_cnt), 64'(err_cnt_mdl));
`endif
  endtask

  function automatic logic [21:0] rand_adr();
    case ($urandom_range(0, 5))
      0, 1, 2: return 22'(($urandom_range(0, 3) << 12) | $urandom_range(0, 4095));
      3, 4:    return 22'((1 << 21) | $urandom_range(0, (1 << 21) - 1));
      default: return 22'(($urandom_range(1, 127) << 14) | $urandom_range(0, (1 << 14) - 1));
    endcase
  endfunction

  initial begin
    int kind, r;
`ifdef SURF_WB_ERR_CAPTURE_EN
    err_cnt_mdl = 0;
`endif
    drive_m(0, 1'b1, 1'b1, 1'b1, 22'h000123, 32'hA5A5A5A5, 4'hF);
    drive_m(1, 1'b0, 1'b0, 1'b0, 22'h0, 32'h0, 4'h0);
    clr_resp();
    repeat (3) @(posedge clk);
    #1 chk("reset_outputs", 64'(all_out()), 64'd0);
    drive_m(0, 1'b0, 1'b0, 1'b0, 22'h0, 32'h0, 4'h0);
    @(negedge clk) rst_n = 1'b1;
    step();

    // tie after reset: m0 first, one idle cycle, then m1, next tie m0 again
    drive_m(0, 1'b1, 1'b1, 1'b0, 22'h000000, 32'h0, 4'h1);
    drive_m(1, 1'b1, 1'b1, 1'b0, 22'h001000, 32'h0, 4'h2);
    step(); chk("arb_tie0", 64'(stbs()), 64'b00001);
    step(); chk("arb_hold0", 64'(stbs()), 64'b00001);
    drive_m(0, 1'b0, 1'b0, 1'b0, 22'h0, 32'h0, 4'h0);
    step(); chk("arb_idle", 64'(stbs()), 64'b00000);
    step(); chk("arb_gnt1", 64'(stbs()), 64'b00010);
    drive_m(1, 1'b0, 1'b0, 1'b0, 22'h0, 32'h0, 4'h0);
    step(); chk("arb_idle2", 64'(stbs()), 64'b00000);
    drive_m(0, 1'b1, 1'b1, 1'b0, 22'h000000, 32'h0, 4'h1);
    drive_m(1, 1'b1, 1'b1, 1'b0, 22'h001000, 32'h0, 4'h2);
    step(); chk("arb_tie1", 64'(stbs()), 64'b00001);
    drive_m(0, 1'b0, 1'b0, 1'b0, 22'h0, 32'h0, 4'h0);
    drive_m(1, 1'b0, 1'b0, 1'b0, 22'h0, 32'h0, 4'h0);
    step(); step();

    // directed cases
    run_txn(0, 22'h002004, 1'b0, 32'h0, 4'hF, 0, 0, 32'hDEADBEEF);
    run_txn(1, 22'h200010, 1'b1, 32'h12345678, 4'hF, 0, 0, 32'h0);
    run_txn(0, 22'h004000, 1'b0, 32'h0, 4'hF, 0, 0, 32'h0);
    run_txn(0, 22'h003008, 1'b0, 32'h0, 4'hF, 0, 2, 32'h0);
    run_txn(1, 22'h001ABC, 1'b1, 32'hCAFEF00D, 4'h3, 2, 1, 32'h0);

    // randomized traffic
    for (int n = 0; n < 60; n++) begin
      r = $urandom_range(0, 9);
      kind = (r < 7) ? 0 : ((r < 9) ? 1 : 2);
      run_txn($urandom_range(0, 1), rand_adr(), 1'($urandom_range(0, 1)), $urandom,
              4'($urandom_range(0, 15)), $urandom_range(0, 3), kind, $urandom);
    end

    // asynchronous reset mid-transfer
    drive_m(0, 1'b1, 1'b1, 1'b0, 22'h002010, 32'h0, 4'hF);
    step(); step();
    chk("pre_rst_stb", 64'(stbs()), 64'b00100);
    #3 rst_n = 1'b0;
    #1 chk("async_rst", 64'(all_out()), 64'd0);
`ifdef SURF_WB_ERR_CAPTURE_EN
    err_cnt_mdl = 0;
    chk("rst_capture", 64'({err_adr, err_src, err_cnt}), 64'd0);
`endif
    drive_m(0, 1'b0, 1'b0, 1'b0, 22'h0, 32'h0, 4'h0);
    @(negedge clk) rst_n = 1'b1;
    step();
    run_txn(1, 22'h000FFC, 1'b0, 32'h0, 4'hF, 1, 0, 32'h0BADF00D);
    run_txn(1, 22'h3FFFFC, 1'b1, 32'h55AA55AA, 4'hC, 0, 0, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end
endmodule
